// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for systolic-array front-end sequencers.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } feeder_state_t;

  localparam int DEFAULT_N = 2;
  localparam int DEFAULT_W = 32;

  // Element type for the default geometry; modules redeclare it with their own W.
  typedef logic [DEFAULT_W-1:0] elem_t;

  // Number of skewed wavefronts needed to stream an N x N operand pair.
  function automatic int feed_len(input int n);
    return 2 * n - 1;
  endfunction

  // Step counter width covering both the feed and the drain phases.
  function automatic int step_width(input int n, input int drain);
    int hi;
    hi = (feed_len(n) > drain) ? feed_len(n) : drain;
    return (hi <= 2) ? 1 : $clog2(hi);
  endfunction

endpackage

// File: rtl/matrix_skewer.sv
// Combinational diagonal skew: lane i carries A[i][t-i], lane j carries B[t-j][j], zero elsewhere.
module matrix_skewer
  import systolic_pkg::*;
#(
  parameter int N  = 2,
  parameter int W  = 32,
  parameter int SW = 2
) (
  input  logic                          i_active,
  input  logic [SW-1:0]                 i_step,
  input  logic [N-1:0][N-1:0][W-1:0]    i_mat_a,
  input  logic [N-1:0][N-1:0][W-1:0]    i_mat_b,
  output logic [N-1:0][W-1:0]           o_lane_a,
  output logic [N-1:0][W-1:0]           o_lane_b
);

  // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
  always_comb begin
    o_lane_a = '0;
    o_lane_b = '0;
    if (i_active) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(i_step) == i + k) begin
            o_lane_a[i] = i_mat_a[i][k];
            o_lane_b[i] = i_mat_b[k][i];
          end
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Sequencer that loads an operand pair, streams skewed wavefronts into the array, drains it and holds the product.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N     = 2,
  parameter int W     = 32,
  parameter int DRAIN = N  // must be >= 1 and equal to the array pipeline depth
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0][N-1:0][W-1:0]    mat_a,
  input  logic [N-1:0][N-1:0][W-1:0]    mat_b,
  output logic                          arr_reset,
  output logic                          arr_en,
  output logic [N-1:0][W-1:0]           arr_A,
  output logic [N-1:0][W-1:0]           arr_B,
  input  logic [N-1:0][N-1:0][W-1:0]    arr_Out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0][N-1:0][W-1:0]    result
);

  localparam int FEED_LEN = feed_len(N);
  localparam int SW       = step_width(N, DRAIN);

  feeder_state_t                 r_state;
  feeder_state_t                 w_state_nxt;
  logic [SW-1:0]                 r_step;
  logic [SW-1:0]                 w_step_nxt;
  logic                          w_accept;
  logic                          w_capture;
  logic [N-1:0][N-1:0][W-1:0]    r_mat_a;
  logic [N-1:0][N-1:0][W-1:0]    r_mat_b;
  logic [N-1:0][N-1:0][W-1:0]    r_result;

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_step_nxt  = '0;
      end
      S_FEED: begin
        if (r_step == SW'(FEED_LEN - 1)) begin
          w_state_nxt = S_DRAIN;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_step == SW'(DRAIN - 1)) begin
          w_state_nxt = S_DONE;
          w_step_nxt  = '0;
          w_capture   = 1'b1;
        end else begin
          w_step_nxt = r_step + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      if (w_capture) r_result <= arr_Out;
    end
  end

  // NOTE: operand registers are deliberately not reset; they are only read after a fresh load.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mat_a <= mat_a;
      r_mat_b <= mat_b;
    end
  end

  matrix_skewer #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_skewer (
    .i_active (r_state == S_FEED),
    .i_step   (r_step),
    .i_mat_a  (r_mat_a),
    .i_mat_b  (r_mat_b),
    .o_lane_a (arr_A),
    .o_lane_b (arr_B)
  );

  // A feeder reset also wipes the array so no stale partial sums survive an abort.
  assign arr_reset = reset || (r_state == S_CLEAR);
  assign arr_en    = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder driving a small behavioural output-stationary 2x2 array.
module tb_systolic_feeder;

  typedef logic [1:0][1:0][31:0] mat_t;
  typedef logic [1:0][31:0]      lane_t;

  logic  clock = 1'b0;
  logic  reset;
  logic  in_valid;
  logic  in_ready;
  mat_t  mat_a;
  mat_t  mat_b;
  logic  arr_reset;
  logic  arr_en;
  lane_t arr_A;
  lane_t arr_B;
  mat_t  arr_Out;
  logic  out_valid;
  logic  out_ready;
  mat_t  result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  systolic_feeder #(.N(2), .W(32), .DRAIN(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .arr_reset (arr_reset),
    .arr_en    (arr_en),
    .arr_A     (arr_A),
    .arr_B     (arr_B),
    .arr_Out   (arr_Out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Array model: A flows right along rows, B flows down columns, each PE accumulates a*b mod 2^32.
  mat_t m_acc, m_a, m_b, ai, bi;
  always_comb begin
    ai[0][0] = arr_A[0];  ai[0][1] = m_a[0][0];
    ai[1][0] = arr_A[1];  ai[1][1] = m_a[1][0];
    bi[0][0] = arr_B[0];  bi[0][1] = arr_B[1];
    bi[1][0] = m_b[0][0]; bi[1][1] = m_b[0][1];
  end
  always @(posedge clock) begin
    if (arr_reset) begin
      m_acc <= '0;
      m_a   <= '0;
      m_b   <= '0;
    end else if (arr_en) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          m_acc[i][j] <= m_acc[i][j] + ai[i][j] * bi[i][j];
      m_a <= ai;
      m_b <= bi;
    end
  end
  assign arr_Out = m_acc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic mat_t mk(input logic [31:0] a00, input logic [31:0] a01,
                              input logic [31:0] a10, input logic [31:0] a11);
    mat_t m;
    m[0][0] = a00; m[0][1] = a01; m[1][0] = a10; m[1][1] = a11;
    return m;
  endfunction

  // Offers one job from IDLE, scrambles the inputs after acceptance, waits for the result.
  task automatic run_job(input string tag, input mat_t a, input mat_t b, input mat_t exp);
    int n;
    mat_a    = a;
    mat_b    = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mat_a    = mk(32'hDEAD, 32'hBEEF, 32'h1234, 32'h5678);
    mat_b    = mk(32'h5555, 32'hAAAA, 32'h7777, 32'h3333);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'd6);
    check({tag, "_result"}, result, exp);
    if (out_ready) begin
      tick();
      check({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea0 [3];
    logic [31:0] ea1 [3];
    logic [31:0] eb0 [3];
    logic [31:0] eb1 [3];
    mat_t        exp1;
    ea0 = '{32'd1, 32'd2, 32'd0};
    ea1 = '{32'd0, 32'd3, 32'd4};
    eb0 = '{32'd5, 32'd7, 32'd0};
    eb1 = '{32'd0, 32'd6, 32'd8};
    exp1 = mk(32'd19, 32'd22, 32'd43, 32'd50);

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mat_a     = '0;
    mat_b     = '0;
    tick();
    tick();
    check("rst_arr_reset_high", arr_reset, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_flags", {out_valid, arr_en, arr_reset}, 3'b000);
    check("rst_lanes", {arr_A, arr_B}, 128'd0);
    check("rst_result", result, 128'd0);

    // Job 1: skew table and latency checked cycle by cycle, result held under backpressure.
    mat_a    = mk(32'd1, 32'd2, 32'd3, 32'd4);
    mat_b    = mk(32'd5, 32'd6, 32'd7, 32'd8);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mat_a    = mk(32'd99, 32'd99, 32'd99, 32'd99);
    mat_b    = mk(32'd77, 32'd77, 32'd77, 32'd77);
    check("clr_flags", {arr_reset, arr_en, in_ready, out_valid}, 4'b1000);
    check("clr_lanes", {arr_A, arr_B}, 128'd0);
    for (int t = 0; t < 3; t++) begin
      tick();
      check($sformatf("feed%0d_en", t), {arr_en, arr_reset}, 2'b10);
      check($sformatf("feed%0d_a0", t), arr_A[0], ea0[t]);
      check($sformatf("feed%0d_a1", t), arr_A[1], ea1[t]);
      check($sformatf("feed%0d_b0", t), arr_B[0], eb0[t]);
      check($sformatf("feed%0d_b1", t), arr_B[1], eb1[t]);
    end
    for (int d = 0; d < 2; d++) begin
      tick();
      check($sformatf("drain%0d_en", d), {arr_en, out_valid}, 2'b10);
      check($sformatf("drain%0d_lanes", d), {arr_A, arr_B}, 128'd0);
    end
    tick();
    check("job1_valid_at_edge6", out_valid, 1'b1);
    check("job1_result", result, exp1);

    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("bp%0d_flags", c), {out_valid, in_ready, arr_en}, 3'b100);
      check($sformatf("bp%0d_result", c), result, exp1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_idle", {in_ready, out_valid}, 2'b10);
    tick();
    check("no_latched_req", {in_ready, arr_reset}, 2'b10);

    // Job 2 with out_ready already high: one-cycle out_valid, then IDLE.
    run_job("job2_identity", mk(32'd1, 32'd0, 32'd0, 32'd1),
            mk(32'd9, 32'd8, 32'd7, 32'd6), mk(32'd9, 32'd8, 32'd7, 32'd6));

    // Reset aborts a job in FEED at t=1.
    mat_a    = mk(32'd1, 32'd2, 32'd3, 32'd4);
    mat_b    = mk(32'd5, 32'd6, 32'd7, 32'd8);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("abort_t1_lanes", {arr_A, arr_B}, {32'd3, 32'd2, 32'd6, 32'd7});
    reset = 1'b1;
    #1;
    check("abort_arr_reset", arr_reset, 1'b1);
    tick();
    check("abort_idle", {in_ready, out_valid, arr_en}, 3'b100);
    check("abort_result_cleared", result, 128'd0);
    reset = 1'b0;
    #1;
    check("abort_arr_reset_low", arr_reset, 1'b0);

    run_job("after_abort", mk(32'd2, 32'd0, 32'd1, 32'd3),
            mk(32'd1, 32'd4, 32'd5, 32'd2), mk(32'd2, 32'd8, 32'd16, 32'd10));
    run_job("wrap", mk(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0),
            mk(32'd2, 32'd0, 32'd0, 32'd0), mk(32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
